// File: rtl/video_timing.sv
// video_timing: raster counters, syncs, blanking, strobes and line interrupt with frame-deferred mode switch
module video_timing #(
  parameter int VACT = 480,
  parameter int VFP  = 10,
  parameter int VSW  = 2,
  parameter int VBP  = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_mode,
  input  logic [9:0] irqline,
  output logic       mode,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       newline,
  output logic       newframe,
  output logic       irq
);
  localparam int VTOTAL = VACT + VFP + VSW + VBP;
  logic [9:0] hn, vn, hlast, hact, hs0, hs1;
  logic       mn, eol, eof;
  // Decodes use the next counter state so registered outputs line up with hpos/vpos
  always_comb begin
    hlast = mode ? 10'd799 : 10'd909;
    eol   = hpos == hlast;
    eof   = eol && vpos == 10'(VTOTAL - 1);
    hn    = eol ? 10'd0 : hpos + 10'd1;
    vn    = eof ? 10'd0 : eol ? vpos + 10'd1 : vpos;
    mn    = eof ? video_mode : mode;
    hact  = mn ? 10'd640 : 10'd704;
    hs0   = mn ? 10'd656 : 10'd736;
    hs1   = mn ? 10'd751 : 10'd843;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos     <= '0;
      vpos     <= '0;
      mode     <= 1'b0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      blank    <= 1'b0;
      newline  <= 1'b0;
      newframe <= 1'b0;
      irq      <= 1'b0;
    end else begin
      hpos     <= hn;
      vpos     <= vn;
      mode     <= mn;
      hsync    <= !(hn >= hs0 && hn <= hs1);
      vsync    <= !(vn >= 10'(VACT + VFP) && vn <= 10'(VACT + VFP + VSW - 1));
      blank    <= hn >= hact || vn >= 10'(VACT);
      newline  <= hn == 10'd0;
      newframe <= hn == 10'd0 && vn == 10'd0;
      irq      <= hn == hact && vn == irqline;
    end
  end
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: random mode/irqline/reset stimulus checked against a frame-time arithmetic model
module tb_video_timing;
  localparam int VACT = 8, VFP = 2, VSW = 2, VBP = 3, VT = VACT + VFP + VSW + VBP;
  logic       clk = 1'b0, reset = 1'b1, video_mode = 1'b1;
  logic [9:0] irqline = '0;
  logic       mode, hsync, vsync, blank, newline, newframe, irq;
  logic [9:0] hpos, vpos;
  int n_checks = 0, n_fail = 0;

  video_timing #(.VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP)) dut (
    .clk(clk), .reset(reset), .video_mode(video_mode), .irqline(irqline),
    .mode(mode), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .blank(blank), .newline(newline), .newframe(newframe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int htot(input bit m); return m ? 800 : 910; endfunction
  function automatic int hact(input bit m); return m ? 640 : 704; endfunction
  function automatic int hss(input bit m);  return m ? 656 : 736; endfunction
  function automatic int hsw(input bit m);  return m ? 96 : 108; endfunction

  initial begin
    int t = 0, fc = 0, h, v, ht, sel;
    bit rm = 1'b0;
    for (int cyc = 0; cyc < 85000; cyc++) begin
      @(posedge clk);
      #1;
      if (reset) begin
        t = 0;
        rm = 1'b0;
        check("rst_mode", mode, 0);
        check("rst_hpos", hpos, 0);
        check("rst_vpos", vpos, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_blank", blank, 0);
        check("rst_newline", newline, 0);
        check("rst_newframe", newframe, 0);
        check("rst_irq", irq, 0);
      end else begin
        if (t == htot(rm) * VT - 1) begin
          t = 0;
          rm = video_mode;
          fc++;
        end else t++;
        ht = htot(rm);
        h = t % ht;
        v = t / ht;
        check("mode", mode, rm);
        check("hpos", hpos, h);
        check("vpos", vpos, v);
        check("hsync", hsync, !(h >= hss(rm) && h < hss(rm) + hsw(rm)));
        check("vsync", vsync, !(v >= VACT + VFP && v < VACT + VFP + VSW));
        check("blank", blank, h >= hact(rm) || v >= VACT);
        check("newline", newline, h == 0);
        check("newframe", newframe, t == 0);
        check("irq", irq, h == hact(rm) && v == int'(irqline));
      end
      reset = cyc < 2 || (cyc >= 40000 && cyc < 40003);
      if (t < htot(rm) * VT - 100 && $urandom_range(0, 1499) == 0) video_mode = ~video_mode;
      if (t == htot(rm) * VT - 40) video_mode = ~fc[0];
      if (t == 0) begin
        sel = $urandom_range(0, 3);
        irqline = sel == 0 ? 10'd0 : sel == 1 ? 10'd600 : 10'($urandom_range(0, VT - 1));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
